// File: rtl/fwd_operand_mux.sv
// Operand-forwarding stage for one source operand: youngest matching producer wins, else RF value.
// Latency: 1 cycle from in_valid to out_valid when there is no hazard or stall.
// Backpressure: stall_in holds the output register; hazard_stall asks upstream to hold its operand.
//
// Ports:
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   in_valid, rs_addr, rf_data operand request, its register address and register-file value
//   src_valid/addr/data/pending per-producer bypass info; index 0 = youngest (EX), then MEM, WB
//   stall_in, flush            hold / kill the output register
//   hazard_stall               combinational: winning producer's result is not yet available
//   out_valid/out_data/out_sel registered operand; sel 0 = rf_data, i+1 = producer i
//   fwd_count, hazard_count    saturating event counters, present only with FWD_MUX_STATS_EN
module fwd_operand_mux #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 3,
  parameter int REG_AW  = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [REG_AW-1:0]            rs_addr,
  input  logic [WIDTH-1:0]             rf_data,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*REG_AW-1:0]    src_addr,
  input  logic [NUM_SRC*WIDTH-1:0]     src_data,
  input  logic [NUM_SRC-1:0]           src_pending,
  input  logic                         stall_in,
  input  logic                         flush,
  output logic                         hazard_stall,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(NUM_SRC+1)-1:0] out_sel
`ifdef FWD_MUX_STATS_EN
  ,
  output logic [15:0]                  fwd_count,
  output logic [15:0]                  hazard_count
`endif
);

  localparam int SEL_W = $clog2(NUM_SRC+1);

  logic [NUM_SRC-1:0] match;
  logic               hit;
  logic               sel_pending;
  logic [WIDTH-1:0]   sel_data;
  logic [SEL_W-1:0]   sel_code;

  // Register 0 is hard-wired zero, so it never matches a producer.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      match[i] = src_valid[i] && (src_addr[i*REG_AW +: REG_AW] == rs_addr) && (rs_addr != '0);
    end
  end

  // Scan oldest to youngest so the lowest matching index is written last and wins.
  // Only the winner's pending bit matters: an older stale match is shadowed anyway.
  always_comb begin
    hit         = 1'b0;
    sel_pending = 1'b0;
    sel_data    = rf_data;
    sel_code    = '0;
    for (int i = NUM_SRC-1; i >= 0; i--) begin
      if (match[i]) begin
        hit         = 1'b1;
        sel_pending = src_pending[i];
        sel_data    = src_data[i*WIDTH +: WIDTH];
        sel_code    = SEL_W'(i + 1);
      end
    end
  end

  assign hazard_stall = in_valid && hit && sel_pending;

  // Flush beats stall; a hazard inserts a bubble but keeps the last operand value visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (stall_in) begin
      out_valid <= out_valid;
    end else if (hazard_stall) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= sel_data;
        out_sel  <= sel_code;
      end
    end
  end

`ifdef FWD_MUX_STATS_EN
  logic take_bubble;
  logic take_fwd;

  assign take_bubble = !flush && !stall_in && hazard_stall;
  assign take_fwd    = !flush && !stall_in && !hazard_stall && in_valid && (sel_code != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_count    <= '0;
      hazard_count <= '0;
    end else begin
      if (take_fwd && (fwd_count != 16'hFFFF)) begin
        fwd_count <= fwd_count + 16'd1;
      end
      if (take_bubble && (hazard_count != 16'hFFFF)) begin
        hazard_count <= hazard_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_operand_mux.sv
// Directed bench for fwd_operand_mux: vector table applied in order, then reset and counter sequences.
// Each vector drives inputs on the falling edge, checks hazard_stall before the rising edge and
// the registered outputs just after it.
module tb_fwd_operand_mux;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [4:0]  rs_addr;
  logic [31:0] rf_data;
  logic [2:0]  src_valid;
  logic [14:0] src_addr;
  logic [95:0] src_data;
  logic [2:0]  src_pending;
  logic        stall_in;
  logic        flush;
  logic        hazard_stall;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
`ifdef FWD_MUX_STATS_EN
  logic [15:0] fwd_count;
  logic [15:0] hazard_count;
`endif

  fwd_operand_mux #(.WIDTH(32), .NUM_SRC(3), .REG_AW(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .rs_addr      (rs_addr),
    .rf_data      (rf_data),
    .src_valid    (src_valid),
    .src_addr     (src_addr),
    .src_data     (src_data),
    .src_pending  (src_pending),
    .stall_in     (stall_in),
    .flush        (flush),
    .hazard_stall (hazard_stall),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_sel      (out_sel)
`ifdef FWD_MUX_STATS_EN
    ,
    .fwd_count    (fwd_count),
    .hazard_count (hazard_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  rs;
    logic [31:0] rf;
    logic [2:0]  sv;
    logic [14:0] sa;
    logic [95:0] sd;
    logic [2:0]  sp;
    logic        st;
    logic        fl;
    logic        e_hz;
    logic        e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_sel;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic iv, input logic [4:0] rs, input logic [31:0] rf,
                              input logic [2:0] sv, input logic [14:0] sa, input logic [95:0] sd,
                              input logic [2:0] sp, input logic st, input logic fl,
                              input logic e_hz, input logic e_ov, input logic [31:0] e_od,
                              input logic [1:0] e_sel);
    vec_t v;
    v.iv = iv; v.rs = rs; v.rf = rf; v.sv = sv; v.sa = sa; v.sd = sd; v.sp = sp;
    v.st = st; v.fl = fl; v.e_hz = e_hz; v.e_ov = e_ov; v.e_od = e_od; v.e_sel = e_sel;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid    = v.iv;
    rs_addr     = v.rs;
    rf_data     = v.rf;
    src_valid   = v.sv;
    src_addr    = v.sa;
    src_data    = v.sd;
    src_pending = v.sp;
    stall_in    = v.st;
    flush       = v.fl;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; rs_addr = '0; rf_data = '0; src_valid = '0; src_addr = '0;
    src_data = '0; src_pending = '0; stall_in = 1'b0; flush = 1'b0;
  endtask

  initial begin
    // addr fields {src2, src1, src0}; data fields {src2, src1, src0}
    tbl[0]  = mk(1, 5'd5,  32'h11,   3'b000, {5'd0, 5'd0, 5'd0},  {32'h0, 32'h0, 32'h0},           3'b000, 0, 0, 0, 1, 32'h11,   2'd0);
    tbl[1]  = mk(1, 5'd5,  32'h55,   3'b101, {5'd5, 5'd0, 5'd5},  {32'hCC, 32'h0, 32'hAA},         3'b000, 0, 0, 0, 1, 32'hAA,   2'd1);
    tbl[2]  = mk(1, 5'd5,  32'h55,   3'b100, {5'd5, 5'd0, 5'd0},  {32'hCC, 32'h0, 32'h0},          3'b000, 0, 0, 0, 1, 32'hCC,   2'd3);
    tbl[3]  = mk(1, 5'd5,  32'h55,   3'b110, {5'd5, 5'd5, 5'd0},  {32'hCC, 32'hBB, 32'h0},         3'b100, 0, 0, 0, 1, 32'hBB,   2'd2);
    tbl[4]  = mk(1, 5'd0,  32'h0,    3'b001, {5'd0, 5'd0, 5'd0},  {32'h0, 32'h0, 32'hFF},          3'b000, 0, 0, 0, 1, 32'h0,    2'd0);
    tbl[5]  = mk(1, 5'd0,  32'h1234, 3'b001, {5'd0, 5'd0, 5'd0},  {32'h0, 32'h0, 32'hFF},          3'b001, 0, 0, 0, 1, 32'h1234, 2'd0);
    tbl[6]  = mk(0, 5'd3,  32'h5,    3'b000, {5'd0, 5'd0, 5'd0},  {32'h0, 32'h0, 32'h0},           3'b000, 0, 0, 0, 0, 32'h1234, 2'd0);
    tbl[7]  = mk(0, 5'd7,  32'h5,    3'b001, {5'd0, 5'd0, 5'd7},  {32'h0, 32'h0, 32'h0},           3'b001, 0, 0, 0, 0, 32'h1234, 2'd0);
    tbl[8]  = mk(1, 5'd7,  32'h5,    3'b001, {5'd0, 5'd0, 5'd7},  {32'h0, 32'h0, 32'h0},           3'b001, 0, 0, 1, 0, 32'h1234, 2'd0);
    tbl[9]  = mk(1, 5'd7,  32'h5,    3'b001, {5'd0, 5'd0, 5'd7},  {32'h0, 32'h0, 32'h42},          3'b000, 0, 0, 0, 1, 32'h42,   2'd1);
    tbl[10] = mk(1, 5'd7,  32'h77,   3'b001, {5'd0, 5'd0, 5'd6},  {32'h0, 32'h0, 32'h42},          3'b000, 0, 0, 0, 1, 32'h77,   2'd0);
    tbl[11] = mk(1, 5'd7,  32'h66,   3'b000, {5'd0, 5'd0, 5'd7},  {32'h0, 32'h0, 32'h99},          3'b000, 0, 0, 0, 1, 32'h66,   2'd0);
    tbl[12] = mk(1, 5'd3,  32'h33,   3'b000, {5'd0, 5'd0, 5'd0},  {32'h0, 32'h0, 32'h0},           3'b000, 0, 0, 0, 1, 32'h33,   2'd0);
    tbl[13] = mk(1, 5'd4,  32'h44,   3'b000, {5'd0, 5'd0, 5'd0},  {32'h0, 32'h0, 32'h0},           3'b000, 1, 1, 0, 0, 32'h33,   2'd0);
    tbl[14] = mk(1, 5'd8,  32'h88,   3'b000, {5'd0, 5'd0, 5'd0},  {32'h0, 32'h0, 32'h0},           3'b000, 0, 0, 0, 1, 32'h88,   2'd0);
    tbl[15] = mk(1, 5'd9,  32'h99,   3'b000, {5'd0, 5'd0, 5'd0},  {32'h0, 32'h0, 32'h0},           3'b000, 1, 0, 0, 1, 32'h88,   2'd0);
    tbl[16] = mk(1, 5'd7,  32'h5,    3'b001, {5'd0, 5'd0, 5'd7},  {32'h0, 32'h0, 32'h1},           3'b001, 1, 0, 1, 1, 32'h88,   2'd0);
    tbl[17] = mk(1, 5'd2,  32'hAB,   3'b000, {5'd0, 5'd0, 5'd0},  {32'h0, 32'h0, 32'h0},           3'b000, 0, 1, 0, 0, 32'h88,   2'd0);
    tbl[18] = mk(1, 5'd10, 32'h5,    3'b011, {5'd0, 5'd10, 5'd4}, {32'h0, 32'h7, 32'h3},           3'b010, 0, 0, 1, 0, 32'h88,   2'd0);
    tbl[19] = mk(1, 5'd10, 32'h5,    3'b011, {5'd0, 5'd10, 5'd10},{32'h0, 32'h7, 32'hDEADBEEF},    3'b010, 0, 0, 0, 1, 32'hDEADBEEF, 2'd1);

    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset out_data", out_data, 32'h0);
    chk("reset out_sel", {30'b0, out_sel}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(tbl[k]);
      #1;
      chk($sformatf("v%0d hazard_stall", k), {31'b0, hazard_stall}, {31'b0, tbl[k].e_hz});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", k), {31'b0, out_valid}, {31'b0, tbl[k].e_ov});
      chk($sformatf("v%0d out_data", k), out_data, tbl[k].e_od);
      chk($sformatf("v%0d out_sel", k), {30'b0, out_sel}, {30'b0, tbl[k].e_sel});
    end

    // Asynchronous reset mid-cycle while a valid operand is held; hazard_stall stays combinational.
    @(negedge clk);
    idle_inputs();
    in_valid = 1'b1; rs_addr = 5'd7; src_valid = 3'b001; src_addr = {5'd0, 5'd0, 5'd7};
    src_pending = 3'b001;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("async reset out_data", out_data, 32'h0);
    chk("async reset out_sel", {30'b0, out_sel}, 32'h0);
    chk("reset hazard_stall live", {31'b0, hazard_stall}, 32'h1);
`ifdef FWD_MUX_STATS_EN
    chk("reset fwd_count", {16'b0, fwd_count}, 32'h0);
    chk("reset hazard_count", {16'b0, hazard_count}, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Three bubbles from the pending producer, then it resolves and loads.
    repeat (3) @(posedge clk);
    #1;
    chk("bubble out_valid", {31'b0, out_valid}, 32'h0);
`ifdef FWD_MUX_STATS_EN
    chk("hazard_count after 3", {16'b0, hazard_count}, 32'h3);
    chk("fwd_count no loads", {16'b0, fwd_count}, 32'h0);
`endif
    @(negedge clk);
    src_pending = 3'b000;
    src_data = {32'h0, 32'h0, 32'h5A5A};
    @(posedge clk);
    #1;
    chk("resolved out_valid", {31'b0, out_valid}, 32'h1);
    chk("resolved out_data", out_data, 32'h5A5A);
    chk("resolved out_sel", {30'b0, out_sel}, 32'h1);

`ifdef FWD_MUX_STATS_EN
    chk("fwd_count after 1", {16'b0, fwd_count}, 32'h1);
    repeat (69999) @(posedge clk);
    #1;
    chk("fwd_count saturated", {16'b0, fwd_count}, 32'hFFFF);
    chk("hazard_count held", {16'b0, hazard_count}, 32'h3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
